// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types and constants: sequencer FSM states,
// RAM bus direction encodings, default widths and the load/store opcodes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Decoder opcodes for the data port; kept here so decoder and controller agree.
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester and RAM-bus signals of the memory access sequencer.
// master: the sequencer itself; slave: fetch/data requesters plus the RAM.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              FReq;
  logic [ADDR_W-1:0] FAddr;
  logic              FAck;
  logic [DATA_W-1:0] FData;
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DAck;
  logic [DATA_W-1:0] DRData;
  logic              MemEn;
  logic              RW;
  logic [ADDR_W-1:0] AddressBus;
  logic [DATA_W-1:0] Dout;
  logic [DATA_W-1:0] Din;
  logic              Busy;

  modport master (
    input  FReq, FAddr, DReq, DWe, DAddr, DWData, Din,
    output FAck, FData, DAck, DRData, MemEn, RW, AddressBus, Dout, Busy
  );

  modport slave (
    output FReq, FAddr, DReq, DWe, DAddr, DWData, Din,
    input  FAck, FData, DAck, DRData, MemEn, RW, AddressBus, Dout, Busy
  );
endinterface

// File: rtl/mem_rr_pick.sv
// Two-requester round-robin picker; a tie goes to whichever side lost last time.
// last_data_q starts at 0, so the first tie after reset goes to the data port.
module mem_rr_pick (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic f_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic gnt_vld_o,
  output logic gnt_data_o
);

  logic last_data_q, last_data_d;

  always_comb begin
    gnt_vld_o   = f_req_i | d_req_i;
    gnt_data_o  = d_req_i & (~f_req_i | ~last_data_q);
    last_data_d = (take_i && gnt_vld_o) ? gnt_data_o : last_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_data_q <= 1'b0;
    else          last_data_q <= last_data_d;
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates fetch and load/store accesses onto the single-port RAM bus, holds
// each access for WAIT_CYCLES cycles, then pulses the granted port's ack.
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input logic                    Clk,
  input logic                    Reset_n,
  mem_access_sequencer_if.master bus
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_data_q, gnt_data_d;
  logic              gnt_vld, gnt_data;

  mem_rr_pick u_pick (
    .clk_i      (Clk),
    .rst_n_i    (Reset_n),
    .f_req_i    (bus.FReq),
    .d_req_i    (bus.DReq),
    .take_i     (state_q == IDLE),
    .gnt_vld_o  (gnt_vld),
    .gnt_data_o (gnt_data)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ACCESS;
      ACCESS:  if (cnt_q == CNT_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus registers are only loaded at grant, so requester inputs may change freely mid-access.
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gnt_data_d = gnt_data_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gnt_data_d = gnt_data;
          addr_d     = gnt_data ? bus.DAddr : bus.FAddr;
          we_d       = gnt_data ? bus.DWe : RW_READ;
          wdata_d    = bus.DWData;
          cnt_d      = '0;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (we_q == RW_READ) rdata_d = bus.Din;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= RW_READ;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gnt_data_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      gnt_data_q <= gnt_data_d;
    end
  end

  always_comb begin
    bus.MemEn      = 1'b0;
    bus.RW         = RW_READ;
    bus.AddressBus = '0;
    bus.Dout       = '0;
    bus.FAck       = 1'b0;
    bus.DAck       = 1'b0;
    bus.FData      = '0;
    bus.DRData     = '0;
    bus.Busy       = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        bus.MemEn      = 1'b1;
        bus.RW         = we_q;
        bus.AddressBus = addr_q;
        bus.Dout       = (we_q == RW_WRITE) ? wdata_q : '0;
      end
      RESP: begin
        bus.FAck   = ~gnt_data_q;
        bus.DAck   = gnt_data_q;
        bus.FData  = gnt_data_q ? '0 : rdata_q;
        bus.DRData = (gnt_data_q && we_q == RW_READ) ? rdata_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences and arbitrates the single-port data RAM between two requesters: the instruction fetch port (read-only) and the load/store data port (LDR read / STR write).
- Sits between the fetch unit / memory controller and the RAM bus (AddressBus, RW, Dout, Din).
- Registers each granted access, holds the bus stable for a fixed number of RAM wait cycles, then returns a one-cycle acknowledge with read data.

Parameters:
ADDR_W, 16, RAM address bus width
DATA_W, 32, data word width
WAIT_CYCLES, 2, cycles the address/control is held on the RAM bus per access (legal range 1..15; 0 is illegal)

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
FReq  input  1  fetch read request; held until FAck
FAddr  input  ADDR_W  fetch address
FAck  output  1  one-cycle fetch completion pulse
FData  output  DATA_W  fetch read data, valid while FAck=1
DReq  input  1  data request; held until DAck
DWe  input  1  1 = STR write, 0 = LDR read
DAddr  input  ADDR_W  data address
DWData  input  DATA_W  store data
DAck  output  1  one-cycle data completion pulse
DRData  output  DATA_W  load data, valid while DAck=1
MemEn  output  1  RAM bus access active
RW  output  1  1 = write, 0 = read
AddressBus  output  ADDR_W  RAM address
Dout  output  DATA_W  RAM write data
Din  input  DATA_W  RAM read data
Busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-low, Reset_n.
- Reset (asynchronous, Reset_n=0): state=IDLE, wait counter=0, LastGntData=0. All outputs are 0, including FAck, DAck, FData, DRData, MemEn, RW, AddressBus, Dout and Busy.
- Outputs are always driven, never Z.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one of FReq/DReq is high, grant it.
  - If both are high, grant the requester not granted last (LastGntData=1 grants fetch, else data). After reset, data wins the first tie.
  - On grant, latch address, write-enable (fetch forces 0) and write data into bus registers; set LastGntData; set counter=0; go to ACCESS.
  - With no request, stay in IDLE with the bus at 0.
- ACCESS:
  - MemEn=1; AddressBus, RW and Dout come from the latched registers.
  - Dout=0 for reads.
  - The bus is stable for exactly WAIT_CYCLES cycles and the counter increments each cycle.
  - In the cycle where counter==WAIT_CYCLES-1:
    - Read: capture Din into the granted port's read-data register.
    - Either access: go to RESP.
- RESP:
  - MemEn=0 and the bus returns to 0.
  - Assert FAck or DAck (granted port only) for exactly one cycle; FData/DRData hold the captured word.
  - Go to IDLE.
  - For writes, DRData=0.
- FData/DRData:
  - Return to 0 when not acked.
- Latency:
  - Request seen high in IDLE at cycle 0 → ACCESS in cycles 1..WAIT_CYCLES → Ack in cycle WAIT_CYCLES+1.
  - With the default, Ack comes in cycle 3.
- Requester rule:
  - Drop Req in the cycle after Ack.
  - Req still high in IDLE is a new request, so back-to-back accesses are legal (one IDLE cycle between accesses).
- Input changes: changes to address/data inputs after grant have no effect on the access in flight.
- Reset mid-operation: the access is aborted, no Ack is issued, and all outputs go to 0 immediately.
- Counter: width is ceil(log2(WAIT_CYCLES+1)); it never wraps within an access.
- Both Acks are never high in the same cycle.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - RW_READ=0, RW_WRITE=1
  - ADDR_W/DATA_W defaults
  - the LDR/STR opcode constants 4'b1101/4'b1110, shared with the memory controller and decoder
- One sub-module, mem_rr_pick: a two-requester round-robin picker with LastGntData state. All else stays inline.

Test Plan:
- Reset: assert Reset_n=0 mid-ACCESS of a write to 0x0040 → all outputs 0 that same cycle; no DAck after release; Busy=0.
- Fetch read, WAIT_CYCLES=2: FReq=1, FAddr=0x0010, RAM Din=0xDEADBEEF → MemEn=1, RW=0, AddressBus=0x0010 in cycles 1–2; FAck=1 with FData=0xDEADBEEF in cycle 3 only.
- Store: DReq=1, DWe=1, DAddr=0x0020, DWData=0x12345678 → RW=1, Dout=0x12345678 for 2 cycles; DAck in cycle 3; DRData=0; RAM word 0x0020 reads back 0x12345678.
- Contention after reset: FReq and DReq both high → data served first (DAck in cycle 3), then fetch (FAck in cycle 7). Repeat with both held → grants alternate F, D, F.
- Back-to-back: DReq held through DAck for LDR 0x0030 → second access starts one IDLE cycle later; the inputs changed in the Ack cycle are used; no overlapping Acks.
- Parameter sweep WAIT_CYCLES=1 and 5: Ack occurs exactly in cycle WAIT_CYCLES+1; the bus stays stable for WAIT_CYCLES cycles.
